float_result_checker: RTL and testbench
=======================================

# float_result_checker

Self-checking sink for float_24_8 result streams. It consumes the output stream of a DUT, such as sigmoid, after a known pipeline latency. Each sample is compared against an expected-value memory with a ULP tolerance, and the block reports a mismatch count, the first failing index, and a pass/done verdict. It is the receive/compare end of the stimulus path that streams input vectors from memory into a DUT, and it replaces file dumps plus offline diffing.

## Interface
Parameters:
- LATENCY, 4: number of leading valid samples discarded after start (DUT pipeline fill)
- NUM_SAMPLES, 1000000: samples compared per run
- ADDR_W, 20: expected-memory address width
- TOL_ULP, 2: maximum allowed ordered-integer distance for a match

Ports:
- clk, input, 1: single clock, rising edge
- reset, input, 1: synchronous, active-low (reset==0 clears all state on the clock edge)
- start, input, 1: one-cycle pulse; begins a run from IDLE or DONE
- in_valid, input, 1: DUT output sample valid
- in_data, input, 32: DUT output, float_24_8
- exp_addr, output, ADDR_W: expected-memory read address (registered)
- exp_data, input, 32: expected float_24_8; synchronous memory, valid one cycle after exp_addr
- busy, output, 1: high in ALIGN or RUN
- done, output, 1: high in DONE
- pass, output, 1: done && err_count==0
- err_count, output, 32: mismatches this run, saturating at 32'hFFFF_FFFF
- first_err_idx, output, ADDR_W: index of the first mismatch; all-ones if none
- sample_count, output, 32: samples compared this run

## Operation
- Reset values: state=IDLE; busy=done=pass=0; exp_addr=0; err_count=sample_count=0; first_err_idx=all-ones; compare stage invalid.
- IDLE: on start, go to ALIGN. Clear counters, idx=0, skip=0, first_err_idx=all-ones.
- ALIGN: each in_valid cycle increments skip and the sample is dropped. At skip==LATENCY-1 with in_valid, go to RUN. If LATENCY==0, start goes directly to RUN.
- RUN: on in_valid, stage 1 latches in_data into d1 and sets v1=1, and idx increments. exp_addr always equals the current idx.
- RUN, stage 2 (next cycle, v1=1): compare d1 with exp_data, increment sample_count, and on mismatch increment err_count (saturating). first_err_idx is written only while it is all-ones.
- RUN exit: when the sample with idx==NUM_SAMPLES-1 is accepted, go to DONE after its stage-2 compare. Further in_valid is ignored.
- DONE: outputs hold. start re-arms the block: clear everything and go to ALIGN.
- start while busy is ignored.
- Compare rule:
  - Both operands NaN (exp=FF, mantissa≠0) → match. Exactly one NaN → mismatch.
  - Otherwise map each operand to an ordered integer: non-negative x → x; negative x → -(x & 7FFF_FFFF). The ±0 values therefore both map to 0.
  - |a-b| ≤ TOL_ULP → match. The difference is computed at 33 bits so it cannot overflow.
  - ±Inf compare as ordered values, so Inf vs max-finite is 1 ULP.
- in_valid gaps are allowed at any time. No valid means no index advance and no compare.

## Timing
- Accepted sample at cycle t is paired with exp_addr at t; exp_data is used at t+1.
- err_count and sample_count update at the t+1 edge, visible at t+2.
- done rises 2 cycles after the last sample is accepted.
- Back-to-back valids sustain one compare per cycle. There is no backpressure; the block is always ready.
- Reset asserted mid-run: the next edge gives the full reset values. The in-flight stage-2 compare is discarded.
- start and the reset edge in the same cycle: reset wins.

## Structure
- The shared types package holds:
  - the float_24_8 typedef (sign, 8-bit exponent, 23-bit mantissa)
  - constants FLOAT_EXP_MAX=8'hFF and ERR_SAT=32'hFFFF_FFFF
  - a to_ordered() function
- Sub-module float_ulp_compare: combinational, with parameter TOL_ULP; inputs a, b; output match. It is reusable by other checkers.
- The top level holds the state machine (IDLE/ALIGN/RUN/DONE), the idx/skip counters, the stage-1 register, and the result registers.

## Test plan
- NUM_SAMPLES=16, LATENCY=4; the DUT stream equals expected after 4 junk samples → done after last+2 cycles, pass=1, err_count=0, sample_count=16.
- Sample 5 = expected+3 ULP, sample 9 = expected+2 ULP, TOL_ULP=2 → err_count=1, first_err_idx=5, pass=0.
- Special values, each pair paired as written → err_count=2:
  - 0x80000000 vs 0x00000000 → match.
  - 0x7FC00000 vs 0x7F800001 → match.
  - 0x7FC00000 vs 0x3F800000 → mismatch.
  - 0x3F800000 vs 0xBF800000 → mismatch.
- Random in_valid gaps (50% duty) over 16 samples → identical results to the gap-free run; exp_addr advances only on valid.
- reset=0 for one cycle at sample 7, then start → clean rerun, counters from 0, pass=1.
- start pulsed during RUN → ignored. start in DONE → counters cleared, ALIGN re-entered, 4 samples discarded again.

Source files
------------

// File: rtl/float_result_checker_pkg.sv
// Shared float_24_8 types, constants and the ordered-integer mapping used by result checkers.
package float_result_checker_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float_24_8_t;

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_RUN, S_DONE} state_t;

  localparam logic [7:0]  FLOAT_EXP_MAX = 8'hFF;
  localparam logic [31:0] ERR_SAT       = 32'hFFFF_FFFF;

  // Sign-magnitude to two's complement, so +0 and -0 both land on 0 and adjacent floats differ by 1.
  function automatic logic signed [32:0] to_ordered(input logic [31:0] x);
    if (x[31])
      return -$signed({2'b00, x[30:0]});
    else
      return $signed({1'b0, x});
  endfunction

endpackage

// File: rtl/float_ulp_compare.sv
// Combinational float_24_8 equality within TOL_ULP ordered steps; NaN only matches NaN.
module float_ulp_compare
  import float_result_checker_pkg::*;
#(
  parameter int TOL_ULP = 2
) (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        match
);

  float_24_8_t        fa, fb;
  logic               nan_a, nan_b;
  logic signed [32:0] diff, mag;

  always_comb begin
    fa    = a;
    fb    = b;
    nan_a = (fa.exp == FLOAT_EXP_MAX) && (fa.man != '0);
    nan_b = (fb.exp == FLOAT_EXP_MAX) && (fb.man != '0);
    diff  = to_ordered(a) - to_ordered(b);
    mag   = (diff < 0) ? -diff : diff;
    if (nan_a || nan_b)
      match = nan_a && nan_b;
    else
      match = (mag <= $signed(33'(TOL_ULP)));
  end

endmodule

// File: rtl/float_result_checker.sv
// Self-checking sink: drops LATENCY fill samples, compares NUM_SAMPLES results against
// a synchronous expected memory with ULP tolerance, and latches a pass/done verdict.
module float_result_checker
  import float_result_checker_pkg::*;
#(
  parameter int LATENCY     = 4,
  parameter int NUM_SAMPLES = 1000000,
  parameter int ADDR_W      = 20,
  parameter int TOL_ULP     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [31:0]       exp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [31:0]       err_count,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic [31:0]       sample_count
);

  localparam logic [31:0]       SKIP_LAST = (LATENCY > 0) ? 32'(LATENCY - 1) : 32'd0;
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_SAMPLES - 1);

  state_t            state, state_nx;
  logic [31:0]       skip;
  logic [31:0]       d1;
  logic [ADDR_W-1:0] idx1;
  logic              v1, last1, fed_last;
  logic              clear, accept, match;

  float_ulp_compare #(.TOL_ULP(TOL_ULP)) u_cmp (
    .a     (d1),
    .b     (exp_data),
    .match (match)
  );

  always_comb begin
    state_nx = state;
    clear    = 1'b0;
    accept   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          clear    = 1'b1;
          state_nx = (LATENCY == 0) ? S_RUN : S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (in_valid && skip == SKIP_LAST) state_nx = S_RUN;
      end
      S_RUN: begin
        // Once the final index is taken the stream is ignored while its compare drains.
        accept = in_valid && !fed_last;
        if (v1 && last1) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      exp_addr      <= '0;
      skip          <= '0;
      d1            <= '0;
      idx1          <= '0;
      v1            <= 1'b0;
      last1         <= 1'b0;
      fed_last      <= 1'b0;
      err_count     <= '0;
      sample_count  <= '0;
      first_err_idx <= '1;
    end else begin
      state <= state_nx;
      if (clear) begin
        exp_addr      <= '0;
        skip          <= '0;
        v1            <= 1'b0;
        last1         <= 1'b0;
        fed_last      <= 1'b0;
        err_count     <= '0;
        sample_count  <= '0;
        first_err_idx <= '1;
      end else begin
        if (state == S_ALIGN && in_valid) skip <= skip + 32'd1;
        v1    <= accept;
        last1 <= accept && (exp_addr == IDX_LAST);
        if (accept) begin
          d1       <= in_data;
          idx1     <= exp_addr;
          exp_addr <= exp_addr + 1'b1;
          if (exp_addr == IDX_LAST) fed_last <= 1'b1;
        end
        // exp_data now holds the word addressed when d1 was captured.
        if (v1) begin
          sample_count <= sample_count + 32'd1;
          if (!match) begin
            if (err_count != ERR_SAT) err_count <= err_count + 32'd1;
            if (first_err_idx == '1) first_err_idx <= idx1;
          end
        end
      end
    end
  end

  assign busy = (state == S_ALIGN) || (state == S_RUN);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_float_result_checker.sv
// Scoreboarded random bench for float_result_checker with a behavioural float compare model.
module tb_float_result_checker;

  localparam int LAT = 4;
  localparam int NS  = 16;
  localparam int AW  = 8;
  localparam int TOL = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = '0;
  logic [31:0]   exp_data = '0;
  logic [AW-1:0] exp_addr;
  logic          busy, done, pass;
  logic [31:0]   err_count, sample_count;
  logic [AW-1:0] first_err_idx;

  always #5 clk = ~clk;

  float_result_checker #(
    .LATENCY(LAT), .NUM_SAMPLES(NS), .ADDR_W(AW), .TOL_ULP(TOL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .exp_addr      (exp_addr),
    .exp_data      (exp_data),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .sample_count  (sample_count)
  );

  typedef struct {
    int            err;
    logic [AW-1:0] first;
    bit            pass;
    int            cnt;
    int            done_cyc;
  } res_t;

  logic [31:0] exp_mem [NS];
  logic [31:0] dut_val [NS];
  res_t        sb_q [$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          done_events = 0;
  bit          gaps_en = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Synchronous expected memory: one cycle read latency.
  initial forever begin
    @(posedge clk);
    exp_data <= exp_mem[exp_addr[3:0]];
  end

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit ref_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic longint ref_ord(input logic [31:0] x);
    longint mag;
    mag = longint'(x[30:0]);
    return x[31] ? -mag : mag;
  endfunction

  function automatic bit ref_match(input logic [31:0] a, input logic [31:0] b);
    longint d;
    if (ref_is_nan(a) || ref_is_nan(b)) return ref_is_nan(a) && ref_is_nan(b);
    d = ref_ord(a) - ref_ord(b);
    if (d < 0) d = -d;
    return d <= TOL;
  endfunction

  function automatic logic [31:0] rand_float();
    return {1'($urandom_range(1, 0)), 8'($urandom_range(150, 100)), 23'($urandom)};
  endfunction

  task automatic cyc_next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d);
    if (gaps_en)
      while ($urandom_range(1, 0) == 1) begin
        cyc_next();
        start    = 1'b0;
        in_valid = 1'b0;
      end
    cyc_next();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
  endtask

  task automatic run(input bit gaps, input bit poke_start, input int abort_at);
    res_t r;
    int   target;
    r.err   = 0;
    r.first = '1;
    r.cnt   = NS;
    for (int k = 0; k < NS; k++)
      if (!ref_match(dut_val[k], exp_mem[k])) begin
        r.err++;
        if (r.first == '1) r.first = AW'(k);
      end
    r.pass   = (r.err == 0);
    target   = done_events + 1;
    gaps_en  = gaps;

    cyc_next();
    start    = 1'b1;
    in_valid = 1'b0;
    for (int j = 0; j < LAT; j++) begin
      drive($urandom);
      if (j == 0) begin
        check("armed_busy", busy, 1);
        check("armed_done", done, 0);
        check("armed_err_count", err_count, 0);
        check("armed_sample_count", sample_count, 0);
      end
    end
    for (int k = 0; k < NS; k++) begin
      drive(dut_val[k]);
      check("exp_addr_tracks_idx", exp_addr, k);
      if (poke_start && k == 10) start = 1'b1;
      if (k == abort_at) begin
        reset = 1'b0;
        cyc_next();
        reset    = 1'b1;
        in_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_err_count", err_count, 0);
        check("abort_sample_count", sample_count, 0);
        check("abort_first_err_idx", first_err_idx, 255);
        check("abort_exp_addr", exp_addr, 0);
        return;
      end
      if (k == NS - 1) begin
        r.done_cyc = cyc + 2;
        sb_q.push_back(r);
      end
    end
    repeat (3) drive($urandom);
    cyc_next();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && done_events < target; i++) cyc_next();
    check("done_seen_in_budget", done_events, target);
  endtask

  // Monitor: each rising done is matched against the oldest scoreboard entry.
  initial begin
    bit   prev;
    res_t r;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !prev) begin
        done_events++;
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1, required no verdict pending");
        end else begin
          r = sb_q.pop_front();
          check("verdict_err_count", err_count, r.err);
          check("verdict_first_err_idx", first_err_idx, r.first);
          check("verdict_pass", pass, r.pass);
          check("verdict_sample_count", sample_count, r.cnt);
          check("verdict_done_cycle", cyc, r.done_cyc);
          check("verdict_busy", busy, 0);
        end
      end
      prev = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end, required $finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < NS; k++) exp_mem[k] = rand_float();
    repeat (3) cyc_next();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_exp_addr", exp_addr, 0);
    check("rst_err_count", err_count, 0);
    check("rst_sample_count", sample_count, 0);
    check("rst_first_err_idx", first_err_idx, 255);
    reset = 1'b1;

    // Clean stream.
    for (int k = 0; k < NS; k++) dut_val[k] = exp_mem[k];
    run(0, 0, -1);

    // Out-of-tolerance and at-tolerance samples, plus a start pulse mid-run.
    dut_val[5] = exp_mem[5] + 32'd3;
    dut_val[9] = exp_mem[9] + 32'd2;
    run(0, 1, -1);

    // Special values.
    for (int k = 0; k < NS; k++) dut_val[k] = exp_mem[k];
    dut_val[0] = 32'h8000_0000; exp_mem[0] = 32'h0000_0000;
    dut_val[1] = 32'h7FC0_0000; exp_mem[1] = 32'h7F80_0001;
    dut_val[2] = 32'h7FC0_0000; exp_mem[2] = 32'h3F80_0000;
    dut_val[3] = 32'h3F80_0000; exp_mem[3] = 32'hBF80_0000;
    dut_val[4] = 32'h7F80_0000; exp_mem[4] = 32'h7F7F_FFFF;
    run(0, 0, -1);

    // Random perturbations, without and then with valid gaps.
    for (int k = 0; k < NS; k++) begin
      exp_mem[k] = rand_float();
      dut_val[k] = exp_mem[k] + 32'($signed($urandom_range(6, 0)) - 3);
    end
    run(0, 0, -1);
    run(1, 0, -1);

    // Reset in the middle of a run, then a clean rerun.
    for (int k = 0; k < NS; k++) begin
      exp_mem[k] = rand_float();
      dut_val[k] = exp_mem[k];
    end
    dut_val[3] = exp_mem[3] + 32'd5;
    run(1, 0, 7);
    dut_val[3] = exp_mem[3];
    run(0, 0, -1);

    repeat (4) cyc_next();
    check("scoreboard_drained", sb_q.size(), 0);
    check("verdict_count", done_events, 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
